mbank_arbiter: RTL and testbench
================================

Name: mbank_arbiter

Overview:
Round-robin arbiter that shares one mbank_controller (32x8 memory bank, one outstanding op) between N independent requesters, e.g. the AXI write path, the AXI read path and a scrub/init engine. It latches the winner's command and issues it to the controller as a one-cycle req pulse. It tracks controller busy to completion, then returns read data and a one-cycle ack to the winner. A timeout guards against a hung controller.

Parameters:
N_REQ, 2, number of requesters (2..8)
ADDR_W, 5, address width (matches controller)
DATA_W, 8, data width (matches controller)
TIMEOUT, 64, max cycles waiting in WAIT_ACC plus WAIT_DONE before abort

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  asynchronous, active-high reset
m_req  in  N_REQ  per-requester level request, held until its m_ack
m_we  in  N_REQ  per-requester write enable (1=write)
m_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
m_din  in  N_REQ*DATA_W  packed write data
m_ack  out  N_REQ  one-hot one-cycle completion pulse
m_err  out  N_REQ  one-cycle timeout pulse, coincident with m_ack
m_rdata  out  DATA_W  read data, valid in m_ack cycle for read ops
c_req  out  1  controller request pulse
c_we  out  1  controller write enable
c_addr  out  ADDR_W  controller address
c_din  out  DATA_W  controller write data
c_dout  in  DATA_W  controller read data
c_busy  in  1  controller operation in progress
c_ready  in  1  controller idle/ready

Behaviour:
- Reset (async, rst=1): state IDLE; rr_ptr=0; all outputs 0 (c_req, c_we, c_addr, c_din, m_ack, m_err, m_rdata). Reset during any state aborts the op silently, with no ack.
- All outputs registered.
- FSM:
  - IDLE: if |m_req and c_ready, pick the first requesting index at or after rr_ptr, wrapping modulo N_REQ. Latch g, we, addr, din; go to ISSUE.
  - ISSUE: c_req=1 for exactly this cycle, with c_we/c_addr/c_din from the latch. Clear timer; go to WAIT_ACC.
  - WAIT_ACC: wait for c_busy=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for c_busy=0, then go to RESP.
  - RESP: m_ack[g]=1; m_rdata=c_dout if read, otherwise unchanged; rr_ptr=(g+1) mod N_REQ; go to IDLE.
- c_we, c_addr and c_din hold their values from ISSUE until the next ISSUE.
- Timeout: the timer counts the cycles spent in WAIT_ACC plus WAIT_DONE. When it reaches TIMEOUT, go to RESP with m_err[g]=1 and m_ack[g]=1, and leave m_rdata unchanged.
- Timer width: $clog2(TIMEOUT+1). The timer saturates and never wraps.
- Latency: m_req seen in IDLE -> c_req 1 cycle later. m_ack comes 1 cycle after c_busy falls.
- Requester contract:
  - Drop m_req, or present a new command, in the cycle after m_ack.
  - m_we, m_addr and m_din must be stable while m_req is high. Changes after the latch cycle are ignored.
- Changes on m_req of non-granted requesters during an op have no effect until the next IDLE.
- Fairness: a requester that holds m_req is granted within N_REQ ops.
- Simultaneous requests are resolved purely by rr_ptr, with no fixed priority.
- c_ready=0 in IDLE blocks arbitration; rr_ptr is unchanged.
- m_req with no bits set: stay in IDLE, no outputs change.

Decomposition:
- Package mbank_pkg holds:
  - the ADDR_W/DATA_W defaults;
  - the FSM enum arb_state_t {IDLE, ISSUE, WAIT_ACC, WAIT_DONE, RESP};
  - the shared localparams with mbank_controller.
- One sub-module, rr_pick: combinational round-robin selector (req vector + pointer -> one-hot grant + index). It is reused by the AXI front-end.

Test Plan:
- Single write: req0 writes addr 3 = 0xA5 with controller WRITE_LATENCY=2 -> exactly one c_req pulse carrying we=1, addr=3, din=0xA5. m_ack[0] comes 1 cycle after busy falls; a later read of addr 3 by req1 returns 0xA5.
- Contention: req0 and req1 asserted together, rr_ptr=0, both held for 4 ops -> grant order 0,1,0,1, never two consecutive grants to one requester.
- Full sweep: req0 writes addr i = i for i=0..31, interleaved with req1 reading the same address -> every read returns i, and m_err is never set.
- Timeout: model the controller with c_busy stuck high after c_req, TIMEOUT=64 -> m_ack[g] and m_err[g] pulse together at timer=64, and the FSM returns to IDLE. The next request proceeds normally once busy is released.
- Reset mid-op: assert rst during WAIT_DONE -> all outputs 0 immediately (async), no m_ack, rr_ptr=0. After reset, a pending req1 is served before req0 only if req0 is absent.
- Ready gating: hold c_ready=0 with req0 high for 10 cycles -> no c_req. Release c_ready -> c_req exactly 1 cycle later.

Source files
------------

// File: rtl/mbank_pkg.sv
// Shared definitions for the memory-bank arbiter and the mbank_controller it fronts.
package mbank_pkg;

    localparam int MBANK_ADDR_W        = 5;
    localparam int MBANK_DATA_W        = 8;
    localparam int MBANK_DEPTH         = 32;
    localparam int MBANK_WRITE_LATENCY = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_ACC  = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } arb_state_t;

endpackage

// File: rtl/mbank_arbiter_rr_pick.sv
// Combinational round-robin selector: first requesting index at or after ptr, wrapping.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan from ptr upward; the first hit wins and later hits are ignored.
    always_comb begin
        logic [IW-1:0] cand;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/mbank_arbiter.sv
// Round-robin arbiter sharing one single-outstanding mbank_controller between N_REQ requesters.
module mbank_arbiter
    import mbank_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = MBANK_ADDR_W,
    parameter int DATA_W  = MBANK_DATA_W,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          m_req,
    input  logic [N_REQ-1:0]          m_we,
    input  logic [N_REQ*ADDR_W-1:0]   m_addr,
    input  logic [N_REQ*DATA_W-1:0]   m_din,
    output logic [N_REQ-1:0]          m_ack,
    output logic [N_REQ-1:0]          m_err,
    output logic [DATA_W-1:0]         m_rdata,
    output logic                      c_req,
    output logic                      c_we,
    output logic [ADDR_W-1:0]         c_addr,
    output logic [DATA_W-1:0]         c_din,
    input  logic [DATA_W-1:0]         c_dout,
    input  logic                      c_busy,
    input  logic                      c_ready
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
    localparam logic [IW-1:0] LAST = IW'(N_REQ - 1);

    arb_state_t          state_q, state_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]       g_idx_q, g_idx_d;
    logic [N_REQ-1:0]    g_oh_q, g_oh_d;
    logic [TW-1:0]       timer_q, timer_d, timer_inc;
    logic                c_req_q, c_req_d, c_we_q, c_we_d;
    logic [ADDR_W-1:0]   c_addr_q, c_addr_d;
    logic [DATA_W-1:0]   c_din_q, c_din_d, m_rdata_q, m_rdata_d;
    logic [N_REQ-1:0]    m_ack_q, m_ack_d, m_err_q, m_err_d;

    logic [N_REQ-1:0]    pick_grant;
    logic [IW-1:0]       pick_idx;
    logic                pick_valid;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req   (m_req),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Next-state and registered-output logic; the c_* registers double as the command latch.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        g_idx_d   = g_idx_q;
        g_oh_d    = g_oh_q;
        timer_d   = timer_q;
        c_req_d   = 1'b0;
        c_we_d    = c_we_q;
        c_addr_d  = c_addr_q;
        c_din_d   = c_din_q;
        m_ack_d   = '0;
        m_err_d   = '0;
        m_rdata_d = m_rdata_q;
        timer_inc = (timer_q == TMAX) ? timer_q : timer_q + TW'(1);
        case (state_q)
            IDLE: begin
                if (pick_valid && c_ready) begin
                    state_d  = ISSUE;
                    g_idx_d  = pick_idx;
                    g_oh_d   = pick_grant;
                    c_req_d  = 1'b1;
                    c_we_d   = m_we[pick_idx];
                    c_addr_d = m_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    c_din_d  = m_din[int'(pick_idx)*DATA_W +: DATA_W];
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT_ACC;
            end
            WAIT_ACC: begin
                timer_d = timer_inc;
                if (timer_inc == TMAX) begin
                    state_d = RESP;
                    m_ack_d = g_oh_q;
                    m_err_d = g_oh_q;
                end else if (c_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    state_d = WAIT_ACC;
                end
            end
            WAIT_DONE: begin
                timer_d = timer_inc;
                // A normal completion on the timeout cycle still counts as success.
                if (!c_busy) begin
                    state_d = RESP;
                    m_ack_d = g_oh_q;
                    if (!c_we_q) begin
                        m_rdata_d = c_dout;
                    end else begin
                        m_rdata_d = m_rdata_q;
                    end
                end else if (timer_inc == TMAX) begin
                    state_d = RESP;
                    m_ack_d = g_oh_q;
                    m_err_d = g_oh_q;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            RESP: begin
                rr_ptr_d = (g_idx_q == LAST) ? '0 : g_idx_q + IW'(1);
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any op in flight without an ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            g_idx_q   <= '0;
            g_oh_q    <= '0;
            timer_q   <= '0;
            c_req_q   <= 1'b0;
            c_we_q    <= 1'b0;
            c_addr_q  <= '0;
            c_din_q   <= '0;
            m_ack_q   <= '0;
            m_err_q   <= '0;
            m_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            g_idx_q   <= g_idx_d;
            g_oh_q    <= g_oh_d;
            timer_q   <= timer_d;
            c_req_q   <= c_req_d;
            c_we_q    <= c_we_d;
            c_addr_q  <= c_addr_d;
            c_din_q   <= c_din_d;
            m_ack_q   <= m_ack_d;
            m_err_q   <= m_err_d;
            m_rdata_q <= m_rdata_d;
        end
    end

    assign c_req   = c_req_q;
    assign c_we    = c_we_q;
    assign c_addr  = c_addr_q;
    assign c_din   = c_din_q;
    assign m_ack   = m_ack_q;
    assign m_err   = m_err_q;
    assign m_rdata = m_rdata_q;

endmodule

// File: tb/tb_mbank_arbiter.sv
// Scoreboard bench for mbank_arbiter with a behavioural 32x8 controller model.
module tb_mbank_arbiter;

    localparam int N  = 2;
    localparam int AW = 5;
    localparam int DW = 8;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    m_req = '0;
    logic [N-1:0]    m_we = '0;
    logic [N*AW-1:0] m_addr = '0;
    logic [N*DW-1:0] m_din = '0;
    logic [N-1:0]    m_ack, m_err;
    logic [DW-1:0]   m_rdata;
    logic            c_req, c_we;
    logic [AW-1:0]   c_addr;
    logic [DW-1:0]   c_din;
    logic [DW-1:0]   c_dout;
    logic            c_busy, c_ready, model_ready;
    bit              ready_en = 1'b1;
    bit              stuck = 1'b0;
    int              lat = 2;

    mbank_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_din(m_din),
        .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata), .c_req(c_req), .c_we(c_we),
        .c_addr(c_addr), .c_din(c_din), .c_dout(c_dout), .c_busy(c_busy), .c_ready(c_ready)
    );

    always #5 clk = ~clk;

    // Controller model: busy for 'lat' cycles after each c_req, or until released when stuck.
    logic [DW-1:0] mem [0:31];
    int cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            c_busy <= 1'b0; model_ready <= 1'b1; cnt <= 0; c_dout <= '0;
        end else if (c_req) begin
            c_busy <= 1'b1; model_ready <= 1'b0; cnt <= lat;
            if (c_we) mem[c_addr] <= c_din;
            else c_dout <= mem[c_addr];
        end else if (c_busy) begin
            if (!stuck && cnt <= 1) begin c_busy <= 1'b0; model_ready <= 1'b1; end
            else cnt <= cnt - 1;
        end
    end
    assign c_ready = model_ready & ready_en;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails = 0;

    task automatic check(string name, int got, int exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic flag_fail(string name);
        checks++;
        fails++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    typedef struct { bit we; logic [AW-1:0] addr; logic [DW-1:0] din; } iss_t;
    typedef struct { int idx; bit err; logic [DW-1:0] rdata; } ack_t;
    iss_t iss_q[$];
    ack_t ack_q[$];
    logic [DW-1:0] ref_mem [0:31];
    logic [DW-1:0] exp_rd = '0;

    // Issue-side expectation: controller command, plus the ack/rdata the requester should see.
    task automatic push_op(int i, bit we, logic [AW-1:0] a, logic [DW-1:0] d, bit err, bit want_ack);
        iss_q.push_back('{we, a, d});
        if (we) ref_mem[a] = d;
        else if (!err) exp_rd = ref_mem[a];
        if (want_ack) ack_q.push_back('{i, err, exp_rd});
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents c_req or m_ack/m_err.
    int  fall_cyc = 0;
    int  iss_cyc = 0;
    bit  busy_prev = 1'b0;
    always @(negedge clk) begin
        iss_t ei;
        ack_t ea;
        if (rst) begin
            busy_prev <= 1'b0;
        end else begin
            busy_prev <= c_busy;
            if (busy_prev && !c_busy) fall_cyc <= cyc;
            if (c_req) begin
                if (iss_q.size() == 0) flag_fail("unexpected_c_req");
                else begin
                    ei = iss_q.pop_front();
                    check("c_we", int'(c_we), int'(ei.we));
                    check("c_addr", int'(c_addr), int'(ei.addr));
                    if (ei.we) check("c_din", int'(c_din), int'(ei.din));
                    iss_cyc <= cyc;
                end
            end
            if (m_ack != '0 || m_err != '0) begin
                if (ack_q.size() == 0) flag_fail("unexpected_m_ack");
                else begin
                    ea = ack_q.pop_front();
                    check("m_ack_grant", int'(m_ack), 1 << ea.idx);
                    check("m_err", int'(m_err), ea.err ? (1 << ea.idx) : 0);
                    check("m_rdata", int'(m_rdata), int'(ea.rdata));
                    if (ea.err) check("timeout_latency", cyc - iss_cyc, TO + 1);
                    else check("ack_after_busy_fall", cyc - fall_cyc, 1);
                end
            end
        end
    end

    task automatic set_cmd(int i, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
        m_we[i] = we;
        m_addr[i*AW +: AW] = a;
        m_din[i*DW +: DW] = d;
        m_req[i] = 1'b1;
    endtask

    task automatic wait_ack(int i);
        int n;
        n = 0;
        while (1) begin
            @(posedge clk); #1;
            if (m_ack[i]) break;
            n++;
            if (n > 300) begin flag_fail($sformatf("ack_wait_expired_req%0d", i)); break; end
        end
    endtask

    task automatic do_op(int i, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
        set_cmd(i, we, a, d);
        wait_ack(i);
        m_req[i] = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_c_req", int'(c_req), 0);
        check("rst_c_we", int'(c_we), 0);
        check("rst_c_addr", int'(c_addr), 0);
        check("rst_c_din", int'(c_din), 0);
        check("rst_m_ack", int'(m_ack), 0);
        check("rst_m_err", int'(m_err), 0);
        check("rst_m_rdata", int'(m_rdata), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single write then read-back through the other requester.
        push_op(0, 1'b1, 5'd3, 8'hA5, 1'b0, 1'b1);
        do_op(0, 1'b1, 5'd3, 8'hA5);
        push_op(1, 1'b0, 5'd3, 8'h00, 1'b0, 1'b1);
        do_op(1, 1'b0, 5'd3, 8'h00);

        // Contention with rr_ptr back at 0: grant order 0,1,0,1.
        push_op(0, 1'b1, 5'd10, 8'h3C, 1'b0, 1'b1);
        push_op(1, 1'b0, 5'd3, 8'h00, 1'b0, 1'b1);
        push_op(0, 1'b1, 5'd11, 8'hC3, 1'b0, 1'b1);
        push_op(1, 1'b0, 5'd10, 8'h00, 1'b0, 1'b1);
        fork
            begin do_op(0, 1'b1, 5'd10, 8'h3C); do_op(0, 1'b1, 5'd11, 8'hC3); end
            begin do_op(1, 1'b0, 5'd3, 8'h00); do_op(1, 1'b0, 5'd10, 8'h00); end
        join

        // Full sweep: simultaneous write i / read i, the write wins by rr_ptr.
        for (int i = 0; i < 32; i++) begin
            push_op(0, 1'b1, AW'(i), DW'(i), 1'b0, 1'b1);
            push_op(1, 1'b0, AW'(i), 8'h00, 1'b0, 1'b1);
            fork
                do_op(0, 1'b1, AW'(i), DW'(i));
                do_op(1, 1'b0, AW'(i), 8'h00);
            join
        end

        // Ready gating: no c_req while c_ready is low, then c_req one cycle after release.
        ready_en = 1'b0;
        set_cmd(0, 1'b0, 5'd10, 8'h00);
        n = 0;
        repeat (10) begin @(posedge clk); #1; if (c_req) n++; end
        check("gated_c_req_count", n, 0);
        push_op(0, 1'b0, 5'd10, 8'h00, 1'b0, 1'b1);
        ready_en = 1'b1;
        @(posedge clk); #1;
        check("c_req_after_ready", int'(c_req), 1);
        wait_ack(0);
        m_req[0] = 1'b0;

        // Timeout: controller busy stuck high; ack+err together, rdata unchanged.
        stuck = 1'b1;
        push_op(0, 1'b0, 5'd5, 8'h00, 1'b1, 1'b1);
        do_op(0, 1'b0, 5'd5, 8'h00);
        stuck = 1'b0;
        push_op(1, 1'b0, 5'd3, 8'h00, 1'b0, 1'b1);
        do_op(1, 1'b0, 5'd3, 8'h00);
        push_op(0, 1'b0, 5'd3, 8'h00, 1'b0, 1'b1);
        do_op(0, 1'b0, 5'd3, 8'h00);

        // Reset during WAIT_DONE of a req1 write (rr_ptr is 1 here).
        lat = 6;
        push_op(1, 1'b1, 5'd7, 8'h77, 1'b0, 1'b0);
        set_cmd(1, 1'b1, 5'd7, 8'h77);
        n = 0;
        while (!c_busy && n < 50) begin @(posedge clk); #1; n++; end
        check("busy_seen_before_reset", int'(c_busy), 1);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_c_req", int'(c_req), 0);
        check("arst_c_we", int'(c_we), 0);
        check("arst_c_addr", int'(c_addr), 0);
        check("arst_c_din", int'(c_din), 0);
        check("arst_m_ack", int'(m_ack), 0);
        check("arst_m_rdata", int'(m_rdata), 0);
        exp_rd = '0;
        lat = 2;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        // With rr_ptr cleared, req0 must beat the still-pending req1.
        push_op(0, 1'b0, 5'd3, 8'h00, 1'b0, 1'b1);
        push_op(1, 1'b1, 5'd7, 8'h77, 1'b0, 1'b1);
        set_cmd(0, 1'b0, 5'd3, 8'h00);
        fork
            begin wait_ack(0); m_req[0] = 1'b0; end
            begin wait_ack(1); m_req[1] = 1'b0; end
        join

        repeat (5) @(posedge clk);
        #1;
        check("issue_queue_drained", iss_q.size(), 0);
        check("ack_queue_drained", ack_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_watchdog (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
